// File: rtl/adder_arb_pkg.sv
// Shared types, constants and the round-robin search for adder_arbiter.
package adder_arb_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ID_MAX_W = 3;   // enough for up to 8 requesters
   localparam int unsigned SRCH_W   = 8;   // search window, max requester count

   // Result-register occupancy
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   // Response payload as seen by a consumer
   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [DATA_W-1:0]   sum;
      logic                cout;
      logic                ovf;
   } rsp_t;

   // First valid index at or after ptr, wrapping at n; returns {found, index}
   function automatic logic [ID_MAX_W:0] next_grant(input logic [SRCH_W-1:0]   valid,
                                                     input logic [ID_MAX_W-1:0] ptr,
                                                     input int unsigned          n);
      logic [ID_MAX_W:0] res;
      int unsigned       idx;
      res = '0;
      for (int unsigned off = 0; off < SRCH_W; off++) begin
         idx = 32'(ptr) + off;
         if (idx >= n) begin
            idx = idx - n;
         end
         if ((off < n) && !res[ID_MAX_W] && valid[idx[ID_MAX_W-1:0]]) begin
            res = {1'b1, idx[ID_MAX_W-1:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/adder.sv
// Existing 32-bit ripple adder with carry in and carry out.
module adder
   import adder_arb_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   output logic [DATA_W-1:0] f,
   output logic              cout
);

   // Unsigned 33-bit sum
   always_comb begin
      {cout, f} = (DATA_W+1)'(a) + (DATA_W+1)'(b) + (DATA_W+1)'(cin);
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among N_REQ requesters, with a
// single registered response slot that can drain and refill in one cycle.
// Optional feature: define ADDER_ARB_OVF_EN to add the signed-overflow
// output rsp_ovf and its register.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [DATA_W*N_REQ-1:0] req_a,
   input  logic [DATA_W*N_REQ-1:0] req_b,
   input  logic [N_REQ-1:0]        req_cin,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_sum,
   output logic                    rsp_cout,
`ifdef ADDER_ARB_OVF_EN
   output logic                    rsp_ovf,
`endif
   output logic [15:0]             grant_cnt
);

   out_state_t          state_q;
   out_state_t          state_d;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_MAX_W:0]   search;
   logic [ID_MAX_W-1:0] gidx;
   logic [ID_MAX_W-1:0] ptr_nxt;
   logic                found;
   logic                slot_free;
   logic                xfer;
   logic [DATA_W-1:0]   a_sel;
   logic [DATA_W-1:0]   b_sel;
   logic                cin_sel;
   logic [DATA_W-1:0]   add_f;
   logic                add_cout;

   assign rsp_valid = (state_q == FULL);

   // Arbitration: slot bypass, round-robin pick, one-hot ready
   always_comb begin
      slot_free = (state_q == EMPTY) || rsp_ready;
      search    = next_grant(SRCH_W'(req_valid), ID_MAX_W'(rr_ptr), N_REQ);
      found     = search[ID_MAX_W];
      gidx      = search[ID_MAX_W-1:0];
      xfer      = rst_n && slot_free && found;
      req_ready = xfer ? (N_REQ'(1) << gidx) : '0;
      ptr_nxt   = (gidx == ID_MAX_W'(N_REQ - 1)) ? '0 : gidx + ID_MAX_W'(1);
   end

   // Grant mux feeding the shared adder
   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      cin_sel = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (gidx == ID_MAX_W'(i)) begin
            a_sel   = req_a[i*DATA_W +: DATA_W];
            b_sel   = req_b[i*DATA_W +: DATA_W];
            cin_sel = req_cin[i];
         end
      end
   end

   adder u_adder (
      .a    (a_sel),
      .b    (b_sel),
      .cin  (cin_sel),
      .f    (add_f),
      .cout (add_cout)
   );

   // Occupancy state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Occupancy next state: fill on transfer, empty on drain without refill
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (xfer) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (xfer) begin
               state_d = FULL;
            end else if (rsp_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Result registers and round-robin pointer load on transfer only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_sum  <= '0;
         rsp_cout <= 1'b0;
         rsp_id   <= '0;
         rr_ptr   <= '0;
      end else if (xfer) begin
         rsp_sum  <= add_f;
         rsp_cout <= add_cout;
         rsp_id   <= ID_W'(gidx);
         rr_ptr   <= ID_W'(ptr_nxt);
      end
   end

   // Accepted-operation counter, wraps at 2^16
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else if (xfer) begin
         grant_cnt <= grant_cnt + 16'd1;
      end
   end

`ifdef ADDER_ARB_OVF_EN
   // Signed overflow: like-signed operands producing an opposite-signed sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_ovf <= 1'b0;
      end else if (xfer) begin
         rsp_ovf <= (a_sel[DATA_W-1] == b_sel[DATA_W-1]) &&
                    (add_f[DATA_W-1] != a_sel[DATA_W-1]);
      end
   end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (4 requesters).
module tb_adder_arbiter;
   import adder_arb_pkg::*;

   localparam int unsigned N = 4;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [32*N-1:0]   req_a;
   logic [32*N-1:0]   req_b;
   logic [N-1:0]      req_cin;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [31:0]       rsp_sum;
   logic              rsp_cout;
`ifdef ADDER_ARB_OVF_EN
   logic              rsp_ovf;
`endif
   logic [15:0]       grant_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] opa [N];
   logic [31:0] opb [N];
   logic        opc [N];
   rsp_t        e;
   rsp_t        held;

   adder_arbiter #(.N_REQ(4), .ID_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
`ifdef ADDER_ARB_OVF_EN
      .rsp_ovf   (rsp_ovf),
`endif
      .grant_cnt (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
      opa[i] = a;
      opb[i] = b;
      opc[i] = c;
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_cin[i]        = c;
   endtask

   // Reference: 33-bit unsigned add plus signed-overflow rule
   function automatic rsp_t model(input int i);
      rsp_t        r;
      logic [32:0] s;
      s      = 33'(opa[i]) + 33'(opb[i]) + 33'(opc[i]);
      r.id   = 3'(i);
      r.sum  = s[31:0];
      r.cout = s[32];
      r.ovf  = (opa[i][31] == opb[i][31]) && (s[31] != opa[i][31]);
      return r;
   endfunction

   task automatic chk_rsp(input string tag, input rsp_t x);
      chk({tag, "_valid"}, 64'(rsp_valid), 64'(1));
      chk({tag, "_id"},    64'(rsp_id),    64'(x.id));
      chk({tag, "_sum"},   64'(rsp_sum),   64'(x.sum));
      chk({tag, "_cout"},  64'(rsp_cout),  64'(x.cout));
`ifdef ADDER_ARB_OVF_EN
      chk({tag, "_ovf"},   64'(rsp_ovf),   64'(x.ovf));
`endif
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, "_sum"},   64'(rsp_sum),   64'(0));
      chk({tag, "_cout"},  64'(rsp_cout),  64'(0));
      chk({tag, "_id"},    64'(rsp_id),    64'(0));
      chk({tag, "_cnt"},   64'(grant_cnt), 64'(0));
      chk({tag, "_ready"}, 64'(req_ready), 64'(0));
`ifdef ADDER_ARB_OVF_EN
      chk({tag, "_ovf"},   64'(rsp_ovf),   64'(0));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < int'(N); i++) set_op(i, 32'd0, 32'd0, 1'b0);

      // Reset values; ready stays low in reset even with valid requests
      req_valid = 4'hF;
      #3;
      chk_reset_vals("reset");
      req_valid = '0;
      #9 rst_n = 1'b1;
      tick();

      // Single request from requester 2: 5+7+1 = 13
      set_op(2, 32'd5, 32'd7, 1'b1);
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      #1 chk("single_ready", 64'(req_ready), 64'(4'b0100));
      tick();
      req_valid = '0;
      e = '{id: 3'd2, sum: 32'd13, cout: 1'b0, ovf: 1'b0};
      chk_rsp("single", e);
      chk("single_cnt", 64'(grant_cnt), 64'(1));
      tick();
      chk("drain_valid", 64'(rsp_valid), 64'(0));
      chk("drain_hold_sum", 64'(rsp_sum), 64'(13));

      // Carry wrap on requester 3 (pointer now at 3)
      set_op(3, 32'hFFFF_FFFF, 32'h0, 1'b1);
      req_valid = 4'b1000;
      #1 chk("wrap_ready", 64'(req_ready), 64'(4'b1000));
      tick();
      e = '{id: 3'd3, sum: 32'h0, cout: 1'b1, ovf: 1'b0};
      chk_rsp("wrap", e);
      chk("wrap_cnt", 64'(grant_cnt), 64'(2));

      // All requesters valid: grants 0,1,2,3,0 back to back
      set_op(0, 32'h0000_0010, 32'h0000_0001, 1'b0);
      set_op(1, 32'h8000_0000, 32'h8000_0000, 1'b1);
      set_op(2, 32'h1234_5678, 32'h0FED_CBA8, 1'b0);
      set_op(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      req_valid = 4'hF;
      #1 chk("rr_ready0", 64'(req_ready), 64'(4'b0001));
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_rsp($sformatf("rr%0d", k), model(k % 4));
         chk($sformatf("rr%0d_cnt", k), 64'(grant_cnt), 64'(3 + k));
         chk($sformatf("rr%0d_next", k), 64'(req_ready), 64'(4'b0001 << ((k + 1) % 4)));
      end

      // Backpressure: 5 cycles, no accepts, response held
      rsp_ready = 1'b0;
      held      = model(0);
      #1 chk("bp_ready_now", 64'(req_ready), 64'(0));
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("bp%0d_ready", k), 64'(req_ready), 64'(0));
         chk_rsp($sformatf("bp%0d", k), held);
         chk($sformatf("bp%0d_cnt", k), 64'(grant_cnt), 64'(7));
      end
      // Release: drain and refill in the same cycle, requester 1 next
      rsp_ready = 1'b1;
      #1 chk("bp_release_ready", 64'(req_ready), 64'(4'b0010));
      tick();
      req_valid = '0;
      chk_rsp("refill", model(1));
      chk("refill_cnt", 64'(grant_cnt), 64'(8));
      tick();
      chk("refill_drain", 64'(rsp_valid), 64'(0));

      // Signed overflow vector on requester 1 (pointer at 2, wraps to 1)
      set_op(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      req_valid = 4'b0010;
      tick();
      e = '{id: 3'd1, sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b1};
      chk_rsp("ovf", e);
      chk("ovf_cnt", 64'(grant_cnt), 64'(9));

      // Async reset while FULL with requesters 1 and 3 pending
      rsp_ready = 1'b0;
      req_valid = 4'b1010;
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1 chk("postrst_ready", 64'(req_ready), 64'(4'b0010));
      tick();
      chk_rsp("postrst", model(1));
      chk("postrst_cnt", 64'(grant_cnt), 64'(1));
      chk("postrst_next", 64'(req_ready), 64'(4'b1000));

      // Counter wrap after 65536 accepts
      req_valid = 4'hF;
      repeat (65533) @(posedge clk);
      tick();
      chk("cnt_max", 64'(grant_cnt), 64'(16'hFFFF));
      tick();
      chk("cnt_wrap", 64'(grant_cnt), 64'(0));
      chk("cnt_wrap_valid", 64'(rsp_valid), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
